// File: rtl/hc4017_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : hc4017_pkg
//  Description : Shared constants and Johnson-ring helpers for the 74HC4017
//                decade counter model.
//  Revision    : 1.0 - initial release
// ============================================================================
package hc4017_pkg;

    // Ring length of the 5-stage Johnson counter
    localparam logic [3:0] MODULUS = 4'd10;
    // Decoded output for count 0
    localparam logic [9:0] Q_RESET = 10'b1;
    // Register contents for count 0
    localparam logic [4:0] J_RESET = 5'b0;

    typedef logic [4:0] johnson_t;

    // A 5-bit word is on the 10-state ring exactly when it has at most one
    // transition between adjacent bits (all-zero, all-one, or one boundary).
    function automatic logic johnson_legal(input johnson_t j);
        logic [2:0] w_edges;
        w_edges = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (j[i] != j[i+1]) begin
                w_edges = w_edges + 3'd1;
            end
        end
        return (w_edges <= 3'd1);
    endfunction

    // One Johnson shift: move left, feed back the inverted MSB
    function automatic johnson_t johnson_next(input johnson_t j);
        return {j[3:0], ~j[4]};
    endfunction

    // One-hot decode of a ring state; off-ring states decode to all zeros.
    // On the first half of the ring the count equals the number of ones;
    // on the second half (MSB set) it equals MODULUS minus the ones.
    function automatic logic [9:0] johnson_decode(input johnson_t j);
        logic [3:0] w_ones;
        logic [3:0] w_idx;
        w_ones = 4'd0;
        for (int i = 0; i < 5; i++) begin
            w_ones = w_ones + {3'b000, j[i]};
        end
        w_idx = j[4] ? (MODULUS - w_ones) : w_ones;
        if (!johnson_legal(j)) begin
            return 10'b0;
        end
        return Q_RESET << w_idx;
    endfunction

endpackage : hc4017_pkg
`default_nettype wire

// File: rtl/hc74_4017_johnson5.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : johnson5
//  Description : 5-bit Johnson register with asynchronous active-low reset,
//                level count enable and off-ring recovery to count 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module johnson5
    import hc4017_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    output logic [4:0] o_j
);

    johnson_t r_j;
    johnson_t w_j_next;
    logic     w_legal;

    // Next-state: hold when disabled, shift on the ring, reload 0 when off-ring
    always_comb begin
        w_legal  = johnson_legal(r_j);
        w_j_next = r_j;
        if (i_en) begin
            if (w_legal) begin
                w_j_next = johnson_next(r_j);
            end else begin
                w_j_next = J_RESET;
            end
        end
    end

    // State register; reset wins over any clock edge while held low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_j <= J_RESET;
        end else begin
            r_j <= w_j_next;
        end
    end

    assign o_j = r_j;

endmodule : johnson5
`default_nettype wire

// File: rtl/hc74_4017.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : hc74_4017
//  Description : 74HC4017 decade counter/divider - Johnson counter with ten
//                one-hot decoded outputs and a divide-by-10 carry out.
//  Revision    : 1.0 - initial release
// ============================================================================
module hc74_4017
    import hc4017_pkg::*;
(
    input  logic       cp0,
    input  logic       _mr,
    input  logic       _cp1,
    output logic [9:0] q,
    output logic       _co
);

    logic [4:0] w_j;
    logic       w_en;

    // _cp1 is a plain level enable sampled by the cp0 rising edge
    assign w_en = ~_cp1;

    johnson5 u_johnson5 (
        .clk   (cp0),
        .rst_n (_mr),
        .i_en  (w_en),
        .o_j   (w_j)
    );

    // Outputs are a pure decode of the register, no extra pipeline stage
    assign q   = johnson_decode(w_j);
    assign _co = ~w_j[4];

endmodule : hc74_4017
`default_nettype wire

// File: tb/tb_hc74_4017.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_hc74_4017
//  Description : Self-checking bench for hc74_4017 against an integer
//                decade-count reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hc74_4017;

    logic       cp0;
    logic       mr_n;
    logic       cp1_n;
    logic [9:0] q;
    logic       co_n;

    int n_cmp  = 0;
    int n_fail = 0;
    // Reference count: 0..9 on the ring, -1 for a forced off-ring state
    int cnt    = 0;

    hc74_4017 dut (
        .cp0  (cp0),
        ._mr  (mr_n),
        ._cp1 (cp1_n),
        .q    (q),
        ._co  (co_n)
    );

    initial cp0 = 1'b0;
    always #20 cp0 = ~cp0;

    function automatic logic [9:0] exp_q(input int c);
        logic [9:0] one;
        one = 10'b1;
        if (c < 0) return 10'b0;
        return one << c;
    endfunction

    function automatic logic exp_co(input int c);
        return (c >= 0 && c < 5);
    endfunction

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_ring(input string tag);
        check({tag, "_q"}, q, exp_q(cnt));
        check({tag, "_co"}, {9'b0, co_n}, {9'b0, exp_co(cnt)});
    endtask

    // One rising edge: update the model from the levels seen at the edge,
    // check before and after the following falling edge.
    task automatic cycle_check(input string tag);
        @(posedge cp0);
        if (mr_n && !cp1_n) begin
            cnt = (cnt < 0) ? 0 : (cnt + 1) % 10;
        end
        #15;
        check_ring({tag, "_hi"});
        #10;
        check_ring({tag, "_lo"});
    endtask

    // Asynchronous reset pulse issued away from any rising edge
    task automatic async_reset(input string tag);
        mr_n = 1'b0;
        #5;
        cnt = 0;
        check_ring(tag);
        #3;
        mr_n = 1'b1;
    endtask

    initial begin
        mr_n  = 1'b1;
        cp1_n = 1'b0;
        #1 mr_n = 1'b0;
        #4;
        cnt = 0;
        check_ring("reset");

        // Clock edges while reset is held low must be ignored
        repeat (3) cycle_check("mr_low");

        // Release mid-cycle, then walk the full decade and wrap
        mr_n = 1'b1;
        for (int i = 0; i < 10; i++) cycle_check("walk");
        check("wrap_q", q, 10'b1);

        // Advance to count 2 then hold with _cp1 high
        repeat (2) cycle_check("adv");
        check("at2_q", q, 10'b100);
        cp1_n = 1'b1;
        repeat (3) cycle_check("hold");
        check("held_q", q, 10'b100);
        cp1_n = 1'b0;

        // Asynchronous reset at count 1 and at count 7
        while (cnt != 1) cycle_check("to1");
        async_reset("rst_at1");
        while (cnt != 7) cycle_check("to7");
        check("at7_co", {9'b0, co_n}, 10'b0);
        async_reset("rst_at7");
        cycle_check("post_rst");

        // Off-ring state 01010: decodes to zero, recovers on enabled edges
        force dut.u_johnson5.r_j = 5'b01010;
        #1;
        cnt = -1;
        check("illegal_q", q, 10'b0);
        check("illegal_co", {9'b0, co_n}, 10'b1);
        release dut.u_johnson5.r_j;
        #1;
        check("illegal_kept_q", q, 10'b0);
        cycle_check("recover1");
        cycle_check("recover2");

        // Randomized enable and reset traffic
        for (int i = 0; i < 200; i++) begin
            cp1_n = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                async_reset("rnd_rst");
            end
            cycle_check("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_hc74_4017
`default_nettype wire
